// File: rtl/i2c_accel_sequencer.sv
// Command sequencer in front of i2c_master: configures an ADXL345-class accelerometer once,
// then periodically burst-reads DATAX0..DATAZ1 and publishes signed X/Y/Z samples.
module i2c_accel_sequencer #(
  parameter int unsigned GC_SYSTEM_CLK    = 50000000,
  parameter int unsigned GC_I2C_CLK       = 200000,
  parameter logic [6:0]  GC_DEV_ADDR      = 7'h53,
  parameter logic [7:0]  GC_DATA_FORMAT   = 8'h0B,
  parameter int unsigned GC_SAMPLE_PERIOD = 500000,
  parameter int unsigned GC_IDLE_GAP      = 2 * GC_SYSTEM_CLK / GC_I2C_CLK
) (
  input  logic               clk,
  input  logic               arst_n,
  output logic               m_valid,
  output logic [6:0]         m_addr,
  output logic               m_rnw,
  output logic [7:0]         m_data_wr,
  input  logic               m_busy,
  input  logic [7:0]         m_data_rd,
  input  logic               m_ack_error,
  output logic signed [15:0] accel_x,
  output logic signed [15:0] accel_y,
  output logic signed [15:0] accel_z,
  output logic               sample_valid,
  output logic               init_done,
  output logic [7:0]         err_cnt
);

  localparam int unsigned PerW = $clog2(GC_SAMPLE_PERIOD);
  localparam int unsigned GapW = $clog2(GC_IDLE_GAP + 1);
  localparam logic [PerW-1:0] PerLast = PerW'(GC_SAMPLE_PERIOD - 1);
  localparam logic [GapW-1:0] GapFull = GapW'(GC_IDLE_GAP);

  typedef enum logic [2:0] {
    StCfgPwr, StCfgFmt, StWait, StBurst, StPublish, StErr
  } state_e;

  state_e          state_q, state_d;
  logic            busy_q, active_q, active_d, valid_q, valid_d, rnw_q, rnw_d;
  logic [7:0]      data_wr_q, data_wr_d;
  logic [2:0]      cmd_idx_q, cmd_idx_d;
  logic            cap_q, cap_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [PerW-1:0] per_q, per_d;
  logic [7:0]      rd_q [6];
  logic [7:0]      rd_d [6];
  logic [15:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic            sv_q, sv_d, init_q, init_d;
  logic [7:0]      err_q, err_d;

  logic       rise, fall, gap_ok, can_start, txn_done, start;
  logic [7:0] wr_reg, wr_val;
  logic [2:0] last_idx;

  assign rise      = m_busy & ~busy_q;
  assign fall      = ~m_busy & busy_q;
  assign gap_ok    = (gap_q == GapFull);
  assign can_start = ~m_busy & gap_ok & ~active_q;
  assign txn_done  = active_q & ~valid_q & gap_ok;
  assign last_idx  = (state_q == StBurst) ? 3'd7 : 3'd2;

  always_comb begin
    wr_reg = 8'h32;
    wr_val = 8'h00;
    case (state_q)
      StCfgPwr: begin wr_reg = 8'h2D; wr_val = 8'h08;           end
      StCfgFmt: begin wr_reg = 8'h31; wr_val = GC_DATA_FORMAT; end
      default:  ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    valid_d   = valid_q;
    rnw_d     = rnw_q;
    data_wr_d = data_wr_q;
    cmd_idx_d = cmd_idx_q;
    cap_d     = cap_q;
    rd_d      = rd_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    sv_d      = 1'b0;
    init_d    = init_q;
    err_d     = err_q;
    start     = 1'b0;
    // End-of-transaction gap: idle cycles with nothing presented and the master not busy.
    gap_d     = (m_busy || valid_q) ? '0 : (gap_ok ? gap_q : gap_q + 1'b1);
    per_d     = (per_q == PerLast) ? '0 : per_q + 1'b1;

    case (state_q)
      StCfgPwr, StCfgFmt, StBurst: start = can_start;
      StWait: begin
        if (per_q == PerLast) begin
          state_d = StBurst;
          start   = can_start;
        end
      end
      StPublish: begin
        x_d     = {rd_q[1], rd_q[0]};
        y_d     = {rd_q[3], rd_q[2]};
        z_d     = {rd_q[5], rd_q[4]};
        sv_d    = 1'b1;
        state_d = StWait;
      end
      StErr: begin
        if (per_q == PerLast) state_d = init_q ? StBurst : StCfgPwr;
      end
      default: state_d = StCfgPwr;
    endcase

    if (start) begin
      active_d  = 1'b1;
      valid_d   = 1'b1;
      rnw_d     = 1'b0;
      data_wr_d = wr_reg;
      cmd_idx_d = 3'd0;
      cap_d     = 1'b0;
      if (state_q != StCfgPwr && state_q != StCfgFmt) per_d = '0;
    end else if (active_q) begin
      if (rise) begin
        // Master latched the presented command; present the next one or withdraw.
        cmd_idx_d = cmd_idx_q + 3'd1;
        cap_d     = 1'b1;
        if (cmd_idx_q + 3'd1 == last_idx) begin
          valid_d = 1'b0;
        end else if (cmd_idx_q == 3'd0) begin
          if (state_q == StBurst) rnw_d = 1'b1;
          else                    data_wr_d = wr_val;
        end
      end else if (fall && cap_q) begin
        cap_d = 1'b0;
        if (state_q == StBurst && cmd_idx_q >= 3'd2) rd_d[cmd_idx_q - 3'd2] = m_data_rd;
      end
    end

    if (txn_done) begin
      active_d = 1'b0;
      if (m_ack_error) begin
        state_d = StErr;
        per_d   = '0;
        err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
      end else begin
        case (state_q)
          StCfgPwr: state_d = StCfgFmt;
          StCfgFmt: begin state_d = StWait; init_d = 1'b1; end
          StBurst:  state_d = StPublish;
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q   <= StCfgPwr;
      busy_q    <= 1'b0;
      active_q  <= 1'b0;
      valid_q   <= 1'b0;
      rnw_q     <= 1'b0;
      data_wr_q <= 8'h00;
      cmd_idx_q <= 3'd0;
      cap_q     <= 1'b0;
      gap_q     <= GapFull;
      per_q     <= '0;
      for (int i = 0; i < 6; i++) rd_q[i] <= 8'h00;
      x_q       <= 16'h0000;
      y_q       <= 16'h0000;
      z_q       <= 16'h0000;
      sv_q      <= 1'b0;
      init_q    <= 1'b0;
      err_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      busy_q    <= m_busy;
      active_q  <= active_d;
      valid_q   <= valid_d;
      rnw_q     <= rnw_d;
      data_wr_q <= data_wr_d;
      cmd_idx_q <= cmd_idx_d;
      cap_q     <= cap_d;
      gap_q     <= gap_d;
      per_q     <= per_d;
      rd_q      <= rd_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      sv_q      <= sv_d;
      init_q    <= init_d;
      err_q     <= err_d;
    end
  end

  assign m_valid      = valid_q;
  assign m_addr       = GC_DEV_ADDR;
  assign m_rnw        = rnw_q;
  assign m_data_wr    = data_wr_q;
  assign accel_x      = x_q;
  assign accel_y      = y_q;
  assign accel_z      = z_q;
  assign sample_valid = sv_q;
  assign init_done    = init_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_i2c_accel_sequencer.sv
// Bench for i2c_accel_sequencer: a bus-functional i2c_master with an ADXL345-like register file
// behind it, directed scenarios and hand-computed expectations.
module tb_i2c_accel_sequencer;

  localparam int unsigned Period = 10000;
  localparam int AddrT = 20;
  localparam int ByteT = 18;
  localparam int LowT  = 2;
  localparam int Stop  = 32'h100;

  localparam int KLog  = 0;
  localparam int KInit = 1;
  localparam int KSv   = 2;
  localparam int KErr  = 3;
  localparam int KRd   = 4;

  logic               clk = 1'b0;
  logic               arst_n = 1'b0;
  logic               m_valid, m_rnw, m_busy, m_ack_error;
  logic [6:0]         m_addr;
  logic [7:0]         m_data_wr, m_data_rd;
  logic signed [15:0] accel_x, accel_y, accel_z;
  logic               sample_valid, init_done;
  logic [7:0]         err_cnt;

  i2c_accel_sequencer #(
    .GC_SAMPLE_PERIOD(Period)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .m_valid     (m_valid),
    .m_addr      (m_addr),
    .m_rnw       (m_rnw),
    .m_data_wr   (m_data_wr),
    .m_busy      (m_busy),
    .m_data_rd   (m_data_rd),
    .m_ack_error (m_ack_error),
    .accel_x     (accel_x),
    .accel_y     (accel_y),
    .accel_z     (accel_z),
    .sample_valid(sample_valid),
    .init_done   (init_done),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   bus_log[$];
  int   sv_cyc[$];
  int   rd_bytes = 0;
  bit   nack_addr = 1'b0;
  logic [7:0] mem [256];
  int   init_seq [8] = '{32'hA6, 32'h2D, 32'h08, Stop, 32'hA6, 32'h31, 32'h0B, Stop};

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (sample_valid) sv_cyc.push_back(cyc);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input int kind, input int target);
    case (kind)
      KLog:    return bus_log.size() >= target;
      KInit:   return init_done == 1'b1;
      KSv:     return sv_cyc.size() >= target;
      KErr:    return int'(err_cnt) >= target;
      default: return rd_bytes >= target;
    endcase
  endfunction

  task automatic wait_for(input int kind, input int target, input int budget, input string tag);
    int n = 0;
    while (!cond(kind, target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(cond(kind, target)), 32'd1);
  endtask

  // Master model: busy rises as each command is latched, falls with read data after its byte.
  initial begin : bfm
    logic       cur_rnw;
    logic [7:0] cur_d;
    logic [7:0] ptr;
    bit         first;
    m_busy = 1'b0;
    m_data_rd = 8'h00;
    m_ack_error = 1'b0;
    ptr = 8'h00;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        cur_rnw = m_rnw;
        cur_d = m_data_wr;
        first = 1'b1;
        m_busy = 1'b1;
        m_ack_error = nack_addr;
        bus_log.push_back(int'({m_addr, cur_rnw}));
        repeat (AddrT) @(negedge clk);
        forever begin
          if (cur_rnw) begin
            m_data_rd = mem[ptr];
            bus_log.push_back(32'h200 | int'(mem[ptr]));
            ptr++;
            rd_bytes++;
          end else begin
            if (first) ptr = cur_d;
            else begin
              mem[ptr] = cur_d;
              ptr++;
            end
            bus_log.push_back(int'(cur_d));
          end
          first = 1'b0;
          repeat (ByteT) @(negedge clk);
          m_busy = 1'b0;
          repeat (LowT) @(negedge clk);
          if (!m_valid) break;
          m_busy = 1'b1;
          if (m_rnw != cur_rnw) begin
            bus_log.push_back(int'({m_addr, m_rnw}));
            if (nack_addr) m_ack_error = 1'b1;
            repeat (AddrT) @(negedge clk);
          end
          cur_rnw = m_rnw;
          cur_d = m_data_wr;
        end
        bus_log.push_back(Stop);
      end
    end
  end

  initial begin : main
    int base, err_at, sv_before;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h32] = 8'h01; mem[8'h33] = 8'h02; mem[8'h34] = 8'h03;
    mem[8'h35] = 8'h04; mem[8'h36] = 8'hFF; mem[8'h37] = 8'h7F;

    // Reset held, then released
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_addr", 32'(m_addr), 32'h53);
    check_eq("rst_data_wr", 32'(m_data_wr), 32'h00);
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_accel_x", 32'(accel_x), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rel_valid", 32'(m_valid), 32'd1);
    check_eq("rel_rnw", 32'(m_rnw), 32'd0);
    check_eq("rel_data_wr", 32'(m_data_wr), 32'h2D);

    // Configuration writes
    wait_for(KLog, 4, 3000, "init_first_stop");
    check_eq("init_done_after_1st", 32'(init_done), 32'd0);
    wait_for(KLog, 8, 3000, "init_second_stop");
    check_eq("init_done_at_2nd_stop", 32'(init_done), 32'd0);
    wait_for(KInit, 0, 2000, "init_done_rise");
    for (int i = 0; i < 8; i++) check_eq($sformatf("init_bus_%0d", i), bus_log[i], init_seq[i]);

    // First burst
    wait_for(KSv, 1, Period + 2000, "sample1");
    check_eq("s1_x", 32'(accel_x), 32'h0201);
    check_eq("s1_y", 32'(accel_y), 32'h0403);
    check_eq("s1_z", 32'(accel_z), 32'h7FFF);
    repeat (3) @(negedge clk);
    check_eq("s1_single_pulse", sv_cyc.size(), 1);

    // Periodic sampling
    wait_for(KSv, 4, 3 * Period + 1000, "sample4");
    for (int i = 1; i < 4; i++)
      check_eq($sformatf("period_%0d", i), sv_cyc[i] - sv_cyc[i-1], Period);
    check_eq("s4_z", 32'(accel_z), 32'h7FFF);

    // Address NACK during a burst, then retry
    mem[8'h32] = 8'h10; mem[8'h33] = 8'h20; mem[8'h34] = 8'h30;
    mem[8'h35] = 8'h40; mem[8'h36] = 8'h50; mem[8'h37] = 8'h60;
    nack_addr = 1'b1;
    sv_before = sv_cyc.size();
    wait_for(KErr, 1, Period + 2000, "err_inc");
    err_at = cyc;
    nack_addr = 1'b0;
    check_eq("err_cnt_1", 32'(err_cnt), 32'd1);
    check_eq("nack_no_sample", sv_cyc.size(), sv_before);
    check_eq("nack_x_kept", 32'(accel_x), 32'h0201);
    check_eq("nack_z_kept", 32'(accel_z), 32'h7FFF);
    base = bus_log.size();
    wait_for(KLog, base + 1, Period + 100, "retry_start");
    check_eq("retry_delay_ok", 32'((cyc - err_at >= Period) && (cyc - err_at <= Period + 3)), 1);
    wait_for(KSv, sv_before + 1, 2000, "retry_sample");
    check_eq("retry_x", 32'(accel_x), 32'h2010);
    check_eq("retry_y", 32'(accel_y), 32'h4030);
    check_eq("retry_z", 32'(accel_z), 32'h6050);
    check_eq("retry_err_cnt", 32'(err_cnt), 32'd1);

    // One-cycle reset during the third data byte of a burst
    base = rd_bytes;
    wait_for(KRd, base + 3, Period + 1000, "burst_byte3");
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rst_valid", 32'(m_valid), 32'd0);
    check_eq("mid_rst_init_done", 32'(init_done), 32'd0);
    check_eq("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("mid_rst_accel_y", 32'(accel_y), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    base = bus_log.size();
    wait_for(KInit, 0, 5000, "reinit_done");
    check_eq("reinit_len", 32'(bus_log.size() >= base + 8), 1);
    if (bus_log.size() >= 8)
      for (int i = 0; i < 8; i++)
        check_eq($sformatf("reinit_bus_%0d", i), bus_log[bus_log.size() - 8 + i], init_seq[i]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
